cache_lru: RTL and testbench
============================

Name: cache_lru

Overview:
- Per-set true-LRU replacement tracker for the 4-way, 2048-set unified cache.
- Takes the set index of the current access and the way it used; when enabled, promotes that way to most-recently-used.
- Reports the least-recently-used way of the addressed set, which the fill logic picks as victim on a miss.
- Sits beside the cache data and tag blocks in the memory system, clocked by main_clk.

Parameters:
- SET_BITS, 11, set-index width; set count = 2**SET_BITS.
- Associativity is fixed at 4 ways (2-bit way index) and is not a parameter.

Ports:
- main_clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- least_used_way  output  2  LRU way of the set sampled at the previous edge (registered).
- lru_addr  input  SET_BITS  set index of the current access.
- lru_used_index  input  2  way touched by the current access.
- enable  input  1  1 = record a use of lru_used_index in set lru_addr at this edge.
- init_done  output  1  1 once every set has been initialised after reset.

Behaviour:
- Per-set state is an 8-bit ordered list of 4 way numbers, 2 bits per slot.
  - slot0 = LRU … slot3 = MRU; the list is always a permutation of {0,1,2,3}.
- Default order: slot0..3 = 0,1,2,3, so the LRU way is 0.
- Update rule on a use of way W:
  - remove W from the list;
  - shift the slots above it down by one;
  - place W in slot3.
  - If W is already MRU, the state is unchanged.
- Storage: synchronous single-port-style array of 2**SET_BITS x 8 bits, inferable as block RAM, with no per-set reset flops.
- Reset, asserted asynchronously:
  - least_used_way=0, init_done=0, and a sweep counter is cleared;
  - the FSM enters INIT.
- INIT state:
  - after rst deasserts, one set per cycle (0,1,…,2**SET_BITS-1) is written with the default order;
  - enable is ignored and least_used_way is held at 0;
  - after the last set is written, the FSM moves to RUN and init_done=1 from the next cycle.
  - INIT lasts 2**SET_BITS cycles (2048 at default).
- RUN state, every edge:
  - read the state of set lru_addr;
  - if enable=1, write the updated order back to that set;
  - register least_used_way = slot0 of the post-update order (write-first); with enable=0 it is slot0 of the current order.
  - Latency: 1 cycle from lru_addr/enable to least_used_way.
- Back-to-back updates to the same set in consecutive cycles must chain correctly: forward the last written value and do not read stale RAM data.
- lru_used_index is don't-care when enable=0.
- Reset asserted mid-RUN or mid-INIT aborts at once and restarts INIT from set 0; prior LRU history is lost.
- X on lru_addr while enable=0 must not corrupt any stored state.

Decomposition:
- Shared package cache_pkg holds:
  - CACHE_WAYS=4, WAY_W=2, SET_BITS default 11;
  - typedef lru_order_t (4 x 2-bit slots);
  - constant LRU_DEFAULT_ORDER = {3,2,1,0}, where slot3 = way 3 and slot0 = way 0.
- One natural sub-module, lru_order_update: purely combinational (order, used_way) -> new_order, lru_way.
- The array, bypass register and INIT FSM stay in cache_lru.

Test Plan:
- Reset then wait: init_done rises exactly 2048 cycles after rst falls; a read of any set (0, 1234, 2047) gives least_used_way=0.
- Set 5, uses of ways 0,1,2 on consecutive cycles (enable=1): least_used_way after each edge = 1, 2, 3.
  - A fourth use of way 3 gives 0.
- Set 7, use way 2 then way 2 again: order becomes 0,1,3,2 and least_used_way stays 0.
  - Then uses of ways 0 and 1 give LRU 1, then 3.
- Interleave set 10 (use 0) and set 11 (use 3) on alternate cycles: set 10 LRU=1; set 11 order is 0,1,2,3, so its LRU stays 0.
  - No cross-set corruption.
- enable=0 with lru_addr sweeping 0..15 after prior updates: the outputs match the recorded orders and the stored state is unchanged on re-read.
- Assert rst mid-RUN after updates to set 5: init_done drops at once, INIT re-runs for 2048 cycles, then set 5 reads LRU=0.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and constants for the 4-way cache replacement logic.
// Each LRU order packs four 2-bit way numbers, with slot0 holding the LRU way.
package cache_pkg;

  localparam int CACHE_WAYS       = 4;
  localparam int WAY_W            = 2;
  localparam int SET_BITS_DEFAULT = 11;

  typedef logic [CACHE_WAYS-1:0][WAY_W-1:0] lru_order_t;

  localparam lru_order_t LRU_DEFAULT_ORDER = {2'd3, 2'd2, 2'd1, 2'd0};

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } lru_state_e;

endpackage

// File: rtl/lru_order_update.sv
// Combinational move-to-MRU of one way within a 4-entry LRU order.
// The slots above the used way shift down by one, and the used way lands in slot3.
module lru_order_update
  import cache_pkg::*;
(
  input  lru_order_t       order_i,
  input  logic [WAY_W-1:0] used_way_i,
  output lru_order_t       new_order_o,
  output logic [WAY_W-1:0] lru_way_o
);

  logic [WAY_W-1:0] hit_slot;
  lru_order_t       nxt;

  always_comb begin
    hit_slot = '0;
    for (int i = 0; i < CACHE_WAYS; i++) begin
      if (order_i[i] == used_way_i) hit_slot = WAY_W'(i);
    end
    nxt = order_i;
    for (int i = 0; i < CACHE_WAYS - 1; i++) begin
      if (WAY_W'(i) >= hit_slot) nxt[i] = order_i[i+1];
    end
    nxt[CACHE_WAYS-1] = used_way_i;
  end

  assign new_order_o = nxt;
  assign lru_way_o   = nxt[0];

endmodule

// File: rtl/cache_lru.sv
// Per-set true-LRU tracker. The order array has a registered read, and the
// write-back happens one edge later. A one-deep bypass covers a re-read of the set just written.
module cache_lru
  import cache_pkg::*;
#(
  parameter int SET_BITS = SET_BITS_DEFAULT
) (
  input  logic                main_clk,
  input  logic                rst,
  output logic [WAY_W-1:0]    least_used_way,
  input  logic [SET_BITS-1:0] lru_addr,
  input  logic [WAY_W-1:0]    lru_used_index,
  input  logic                enable,
  output logic                init_done
);

  localparam int NUM_SETS = 1 << SET_BITS;

  lru_order_t mem [NUM_SETS];

  lru_state_e          state_q;
  logic [SET_BITS-1:0] sweep_q;
  logic                init_done_q;

  logic                vld_p0;
  logic                en_p0;
  logic                fwd_p0;
  logic [SET_BITS-1:0] addr_p0;
  logic [WAY_W-1:0]    way_p0;
  lru_order_t          rd_p0;
  lru_order_t          fwd_order_p0;

  lru_order_t          cur_order;
  lru_order_t          upd_order;
  logic [WAY_W-1:0]    upd_lru;

  logic                wr_en;
  logic [SET_BITS-1:0] wr_addr;
  lru_order_t          wr_data;

  assign cur_order = fwd_p0 ? fwd_order_p0 : rd_p0;

  lru_order_update u_update (
    .order_i     (cur_order),
    .used_way_i  (way_p0),
    .new_order_o (upd_order),
    .lru_way_o   (upd_lru)
  );

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = addr_p0;
    wr_data = upd_order;
    if (state_q == ST_INIT) begin
      wr_en   = 1'b1;
      wr_addr = sweep_q;
      wr_data = LRU_DEFAULT_ORDER;
    end else if (vld_p0 && en_p0) begin
      wr_en = 1'b1;
    end
  end

  // stage p0: read-first array, sampled request, bypass of the write landing this edge
  always_ff @(posedge main_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_p0        <= mem[lru_addr];
    addr_p0      <= lru_addr;
    way_p0       <= lru_used_index;
    fwd_order_p0 <= upd_order;
  end

  always_ff @(posedge main_clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_INIT;
      sweep_q     <= '0;
      init_done_q <= 1'b0;
      vld_p0      <= 1'b0;
      en_p0       <= 1'b0;
      fwd_p0      <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          sweep_q <= sweep_q + 1'b1;
          vld_p0  <= 1'b0;
          en_p0   <= 1'b0;
          fwd_p0  <= 1'b0;
          if (sweep_q == '1) begin
            state_q     <= ST_RUN;
            init_done_q <= 1'b1;
          end
        end
        ST_RUN: begin
          vld_p0 <= 1'b1;
          en_p0  <= enable;
          fwd_p0 <= wr_en && (lru_addr == addr_p0);
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

  // output stage: post-update slot0 when enabled, current slot0 otherwise
  always_comb begin
    least_used_way = '0;
    if (vld_p0) least_used_way = en_p0 ? upd_lru : cur_order[0];
  end

  assign init_done = init_done_q;

endmodule

// File: tb/tb_cache_lru.sv
// Randomised and directed bench for cache_lru, checked against a queue-based
// model in which each set holds its ways ordered from LRU to MRU.
module tb_cache_lru;

  localparam int SB    = 11;
  localparam int NSETS = 1 << SB;

  logic          main_clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    least_used_way;
  logic [SB-1:0] lru_addr = '0;
  logic [1:0]    lru_used_index = '0;
  logic          enable = 1'b0;
  logic          init_done;

  int n_checks = 0;
  int n_errors = 0;
  int ref_q [NSETS][$];

  always #5 main_clk = ~main_clk;

  cache_lru #(.SET_BITS(SB)) dut (
    .main_clk       (main_clk),
    .rst            (rst),
    .least_used_way (least_used_way),
    .lru_addr       (lru_addr),
    .lru_used_index (lru_used_index),
    .enable         (enable),
    .init_done      (init_done)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < NSETS; s++) ref_q[s] = '{0, 1, 2, 3};
  endtask

  // One access: drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input int a, input bit en, input int w, output int got);
    int idx;
    @(negedge main_clk);
    lru_addr       = SB'(a);
    enable         = en;
    lru_used_index = 2'(w);
    @(posedge main_clk);
    #1;
    if (en) begin
      idx = 0;
      for (int i = 0; i < ref_q[a].size(); i++) if (ref_q[a][i] == w) idx = i;
      ref_q[a].delete(idx);
      ref_q[a].push_back(w);
    end
    got = int'(least_used_way);
    check_eq($sformatf("lru_set%0d", a), got, ref_q[a][0]);
  endtask

  task automatic wait_init(input string tag);
    int cycles;
    cycles = 0;
    enable         = 1'b1;
    lru_addr       = SB'(5);
    lru_used_index = 2'd2;
    while (cycles < 5000) begin
      @(posedge main_clk);
      #1;
      cycles++;
      if (cycles == 100) check_eq({tag, "_lru_held"}, int'(least_used_way), 0);
      if (init_done) break;
    end
    check_eq({tag, "_init_cycles"}, cycles, NSETS);
  endtask

  initial begin
    int got;
    int a;
    int prev_a;

    model_reset();
    repeat (3) @(posedge main_clk);
    #1;
    check_eq("rst_lru", int'(least_used_way), 0);
    check_eq("rst_init_done", int'(init_done), 0);
    @(negedge main_clk);
    rst = 1'b0;
    wait_init("boot");

    step(0, 1'b0, 0, got);    check_eq("rd_set0", got, 0);
    step(1234, 1'b0, 0, got); check_eq("rd_set1234", got, 0);
    step(2047, 1'b0, 0, got); check_eq("rd_set2047", got, 0);

    step(5, 1'b1, 0, got); check_eq("s5_use0", got, 1);
    step(5, 1'b1, 1, got); check_eq("s5_use1", got, 2);
    step(5, 1'b1, 2, got); check_eq("s5_use2", got, 3);
    step(5, 1'b1, 3, got); check_eq("s5_use3", got, 0);

    step(7, 1'b1, 2, got); check_eq("s7_use2", got, 0);
    step(7, 1'b1, 2, got); check_eq("s7_use2_again", got, 0);
    step(7, 1'b1, 0, got); check_eq("s7_use0", got, 1);
    step(7, 1'b1, 1, got); check_eq("s7_use1", got, 3);

    for (int k = 0; k < 3; k++) begin
      step(10, 1'b1, 0, got); check_eq("s10_use0", got, 1);
      step(11, 1'b1, 3, got); check_eq("s11_use3", got, 0);
    end

    prev_a = 0;
    for (int k = 0; k < 400; k++) begin
      a = ($urandom_range(0, 1) == 0) ? prev_a : int'($urandom_range(0, 15));
      step(a, bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)), got);
      prev_a = a;
    end

    for (int pass = 0; pass < 2; pass++) begin
      for (int s = 0; s < 16; s++) step(s, 1'b0, int'($urandom_range(0, 3)), got);
    end

    step(5, 1'b1, 0, got);
    step(5, 1'b1, 1, got);
    @(posedge main_clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("midrun_rst_init_done", int'(init_done), 0);
    check_eq("midrun_rst_lru", int'(least_used_way), 0);
    model_reset();
    repeat (2) @(posedge main_clk);
    @(negedge main_clk);
    rst = 1'b0;
    wait_init("rerun");
    step(5, 1'b0, 0, got); check_eq("s5_after_reinit", got, 0);
    step(5, 1'b1, 0, got); check_eq("s5_reinit_use0", got, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
